// File: rtl/multi_channel_debounced_counter_pkg.sv
// Shared types and helpers for the debounced multi-channel counter.
// Provides the debounce state enum and a counter-width function.
package multi_channel_debounced_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_channel_debounced_counter_if.sv
// Button/counter bundle: pulsador, dir, clr in; contador, pulso,
// estable, ovf out. master drives buttons, slave is the counter block.
interface multi_channel_debounced_counter_if #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned WIDTH = 8
);

  logic [N_CH-1:0]       pulsador;
  logic                  dir;
  logic                  clr;
  logic [N_CH*WIDTH-1:0] contador;
  logic [N_CH-1:0]       pulso;
  logic [N_CH-1:0]       estable;
  logic [N_CH-1:0]       ovf;

  modport master (
    output pulsador,
    output dir,
    output clr,
    input  contador,
    input  pulso,
    input  estable,
    input  ovf
  );

  modport slave (
    input  pulsador,
    input  dir,
    input  clr,
    output contador,
    output pulso,
    output estable,
    output ovf
  );

endinterface

// File: rtl/multi_channel_debounced_counter_debounce_channel.sv
// One button: 2-FF sync, debounce FSM, auto-repeat when AUTOREPEAT_EN.
// Ports: clk, rst (async low), pulsador_i -> pulso_o, estable_o.
module debounce_channel
  import multi_channel_debounced_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pulsador_i,
  output logic pulso_o,
  output logic estable_o
);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1
      || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("debounce_channel: bad timing parameters");
  end

  localparam int unsigned DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  db_state_e     state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;
  logic          estable_q, estable_d;
  logic          rpt_pulse;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b00;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulso_q   <= 1'b0;
      estable_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pulsador_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulso_q   <= pulso_d;
      estable_q <= estable_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulso_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == D_LAST) begin
          state_d = PRESSED;
          pulso_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (rpt_pulse) begin
          pulso_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == D_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Level stays high through the release window.
    estable_d = (state_d == PRESSED)
             || (state_d == RELEASE_WAIT);
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned HMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW = cnt_w(HMAX);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;

  // rep_q selects the repeat period once the first hold has elapsed.
  always_comb begin
    hold_d    = hold_q;
    rep_d     = rep_q;
    rpt_pulse = 1'b0;
    if (state_q != PRESSED || !s) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (hold_q == (rep_q ? R_LAST : H_LAST)) begin
      rpt_pulse = 1'b1;
      hold_d    = '0;
      rep_d     = 1'b1;
    end else begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

  assign pulso_o   = pulso_q;
  assign estable_o = estable_q;

endmodule

// File: rtl/multi_channel_debounced_counter.sv
// N_CH debounced buttons driving WIDTH-bit up/down counters; macro AUTOREPEAT_EN.
// Ports: clk, rst (async low), bus (slave: buttons/dir/clr in, counts/flags out).
module multi_channel_debounced_counter
  import multi_channel_debounced_counter_pkg::*;
#(
  parameter int unsigned N_CH            = 2,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SATURATE        = 0,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input logic clk,
  input logic rst,
  multi_channel_debounced_counter_if.slave bus
);

  if (N_CH < 1 || N_CH > 8 || WIDTH < 1) begin : g_bad_cfg
    $error("multi_channel_debounced_counter: bad N_CH/WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = '1;

  logic [N_CH-1:0]       pulso;
  logic [N_CH-1:0]       estable;
  logic [N_CH*WIDTH-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]       ovf_q, ovf_d;
  logic [WIDTH-1:0]      cur, nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .pulsador_i(bus.pulsador[i]),
      .pulso_o   (pulso[i]),
      .estable_o (estable[i])
    );
  end

  // clr wins over a same-cycle pulse: no step, no ovf.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = '0;
    cur   = '0;
    nxt   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cur = cnt_q[i*WIDTH +: WIDTH];
      nxt = cur;
      if (bus.clr) begin
        nxt = '0;
      end else if (pulso[i]) begin
        if (bus.dir) begin
          nxt = cur - WIDTH'(1);
          if (cur == '0) begin
            ovf_d[i] = 1'b1;
            if (SATURATE != 0) nxt = cur;
          end
        end else begin
          nxt = cur + WIDTH'(1);
          if (cur == MAXV) begin
            ovf_d[i] = 1'b1;
            if (SATURATE != 0) nxt = cur;
          end
        end
      end
      cnt_d[i*WIDTH +: WIDTH] = nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.contador = cnt_q;
  assign bus.pulso    = pulso;
  assign bus.estable  = estable;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_multi_channel_debounced_counter.sv
// Directed bench: three instances (8-bit wrap, 4-bit wrap, 4-bit saturate).
// Shared buttons/dir/clr; hand-computed expectations via chk.
module tb_multi_channel_debounced_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pb;
  logic       dir;
  logic       clr;

  int n_pass = 0;
  int n_chk  = 0;

  int pa0, ova, ovb, ovc;

  always #5 clk = ~clk;

  multi_channel_debounced_counter_if #(.N_CH(2), .WIDTH(8)) if_a ();
  multi_channel_debounced_counter_if #(.N_CH(2), .WIDTH(4)) if_b ();
  multi_channel_debounced_counter_if #(.N_CH(2), .WIDTH(4)) if_c ();

  assign if_a.pulsador = pb;
  assign if_a.dir      = dir;
  assign if_a.clr      = clr;
  assign if_b.pulsador = pb;
  assign if_b.dir      = dir;
  assign if_b.clr      = clr;
  assign if_c.pulsador = pb;
  assign if_c.dir      = dir;
  assign if_c.clr      = clr;

  multi_channel_debounced_counter #(
    .N_CH(2), .WIDTH(8), .DEBOUNCE_CYCLES(4), .SATURATE(0),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));

  multi_channel_debounced_counter #(
    .N_CH(2), .WIDTH(4), .DEBOUNCE_CYCLES(4), .SATURATE(0),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  multi_channel_debounced_counter #(
    .N_CH(2), .WIDTH(4), .DEBOUNCE_CYCLES(4), .SATURATE(1),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clr_counts();
    pa0 = 0;
    ova = 0;
    ovb = 0;
    ovc = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      pa0 += int'(if_a.pulso[0]);
      ova += int'(|if_a.ovf);
      ovb += int'(if_b.ovf[1]);
      ovc += int'(if_c.ovf[1]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pb  = 2'b00;
    dir = 1'b0;
    clr = 1'b0;
    tick(3);
    rst = 1'b1;
    clr_counts();
  endtask

  task automatic press(input logic [1:0] m);
    pb = m;
    tick(10);
    pb = 2'b00;
    tick(10);
  endtask

  int bnc [10] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0};

  initial begin
    rst = 1'b0;
    pb  = 2'b01;
    dir = 1'b0;
    clr = 1'b0;
    clr_counts();

    // Reset, button already held.
    tick(3);
    chk("rst_cnt", if_a.contador, 0);
    chk("rst_pulso", if_a.pulso, 0);
    chk("rst_estable", if_a.estable, 0);
    chk("rst_ovf", if_a.ovf, 0);
    chk("rst_nopulse", pa0, 0);
    rst = 1'b1;
    clr_counts();
    tick(6);
    chk("lat_edge6", if_a.pulso[0], 0);
    tick(1);
    chk("lat_edge7", if_a.pulso[0], 1);
    tick(1);
    chk("lat_pulse_len", if_a.pulso[0], 0);
    chk("lat_cnt", if_a.contador[7:0], 1);
    pb = 2'b00;
    tick(12);
    chk("lat_one", pa0, 1);

    // Clean single press.
    do_reset();
    pb = 2'b01;
    tick(6);
    chk("sp_edge6", if_a.pulso[0], 0);
    tick(1);
    chk("sp_edge7", if_a.pulso[0], 1);
    chk("sp_estable", if_a.estable[0], 1);
    tick(13);
    chk("sp_one", pa0, 1);
    chk("sp_cnt", if_a.contador[7:0], 1);
    pb = 2'b00;
    tick(6);
    chk("sp_rel6", if_a.estable[0], 1);
    tick(1);
    chk("sp_rel7", if_a.estable[0], 0);
    tick(5);
    chk("sp_norel", pa0, 1);

    // Bounce, then steady high.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) begin
        pb[0] = bnc[k][0];
        tick(1);
      end
    end
    chk("bn_nopulse", pa0, 0);
    chk("bn_estable", if_a.estable[0], 0);
    pb[0] = 1'b1;
    tick(15);
    chk("bn_one", pa0, 1);
    chk("bn_cnt", if_a.contador[7:0], 1);
    pb = 2'b00;
    tick(10);

    // Wrap (B) and saturate (C) on channel 1.
    do_reset();
    repeat (15) press(2'b10);
    chk("wr_b15", if_b.contador[7:4], 15);
    chk("wr_b15_ovf", ovb, 0);
    press(2'b10);
    chk("wr_b0", if_b.contador[7:4], 0);
    chk("wr_b_ovf1", ovb, 1);
    chk("sat_c15", if_c.contador[7:4], 15);
    chk("sat_c_ovf1", ovc, 1);
    dir = 1'b1;
    press(2'b10);
    chk("wr_down_b", if_b.contador[7:4], 15);
    chk("wr_down_ovf", ovb, 2);
    chk("sat_down_c", if_c.contador[7:4], 14);
    chk("sat_down_ovf", ovc, 1);
    dir = 1'b0;
    press(2'b10);
    press(2'b10);
    chk("wr_up_b", if_b.contador[7:4], 1);
    chk("wr_up_ovf", ovb, 3);
    chk("sat_up_c", if_c.contador[7:4], 15);
    chk("sat_up_ovf", ovc, 2);
    chk("ind_b_ch0", if_b.contador[3:0], 0);

    // Clear beats simultaneous pulses.
    do_reset();
    pb = 2'b11;
    tick(7);
    chk("clr_both_pulse", if_a.pulso, 2'b11);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_prio", if_a.contador, 0);
    chk("clr_noovf", ova, 0);
    pb = 2'b00;
    tick(12);
    press(2'b11);
    chk("clr_next", if_a.contador, 32'h0101);

    // Clamp at zero going down.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    clr_counts();
    dir = 1'b1;
    press(2'b10);
    chk("sat0_c", if_c.contador[7:4], 0);
    chk("sat0_c_ovf", ovc, 1);
    chk("wr0_b", if_b.contador[7:4], 15);
    chk("wr0_b_ovf", ovb, 1);
    dir = 1'b0;

`ifdef AUTOREPEAT_EN
    // Hold: pulses at +0,+20,+28,+36,+44,+52.
    do_reset();
    pb = 2'b01;
    tick(62);
    pb = 2'b00;
    tick(12);
    chk("ar_pulses", pa0, 6);
    chk("ar_cnt", if_a.contador[7:0], 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
